clk_cmd_decoder: RTL and testbench
==================================

# clk_cmd_decoder

UART command decoder for the mm:ss clock: consumes received ASCII bytes from the UART receive register stage and produces run/freeze control, per-digit load strobes with BCD load value, 7-segment display enables and LED-display select. It sits directly upstream of the clock datapath (digit counters) and replaces hard-wired control in the top level. Time entry covers both the clock and the alarm digits, with range checking per digit.

## Interface
- (no parameters; all constants live in the shared package)
- clk  in  1  global 12 MHz clock
- rst  in  1  synchronous reset, active-high
- rx_data_rdy  in  1  byte-valid level from the UART receive register; may stay high several cycles
- rx_data  in  8  received ASCII byte, stable while rx_data_rdy high
- blink  in  1  0.5 s high / 0.5 s low pulse from the seconds generator
- run  out  1  1: clock counts, 0: frozen
- ld_mtens, ld_mones, ld_stens, ld_sones  out  1 each  one-cycle load strobe for the target digit
- ld_alarm  out  1  qualifies ld_* strobes: 0 = clock digits, 1 = alarm digits
- ld_num  out  4  BCD value to load, valid in the strobe cycle
- dsp_mtens, dsp_mones, dsp_stens, dsp_sones  out  1 each  7-segment enable
- sel_led_disp  out  1  LED display source select
- alarm_en  out  1  alarm armed
- busy  out  1  1 while in an entry state

## Operation
- Byte acceptance: a byte is taken only on a rising edge of rx_data_rdy (internal registered edge detect); a level held high is one byte.
- States: IDLE, E_MT, E_MO, E_ST, E_SO. The entry target (clock/alarm) is held in a flag set at entry.
- IDLE commands (upper or lower case):
  - 'R' sets run=1.
  - 'P' sets run=0.
  - 'L' saves run, forces run=0 and goes to E_MT with target clock.
  - 'A' goes to E_MT with target alarm; run is unchanged.
  - 'D' toggles sel_led_disp.
  - 'E' toggles alarm_en.
  - All other bytes are ignored.
- Entry states accept ASCII '0'..'9' only, with limits: E_MT and E_ST accept 0–5, E_MO and E_SO accept 0–9. Out-of-range digits and other bytes are ignored, and the state is held.
- A valid digit pulses the matching ld_* with ld_num = byte[3:0] and ld_alarm = target, then advances E_MT→E_MO→E_ST→E_SO→IDLE.
- ESC (8'h1B) in any entry state returns to IDLE. Digits already loaded stay loaded.
- Leaving clock entry (completion or ESC) restores run to the value saved at 'L'.
- Display enables:
  - In IDLE, or when the target is alarm, all dsp_* = 1.
  - In clock entry, the digit awaiting input has dsp = blink; the other digits have dsp = 1.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, run=0, all ld_*=0, ld_alarm=0, ld_num=0, all dsp_*=1, sel_led_disp=0, alarm_en=0, busy=0, saved run=0.
- Edge detect: a rising rx_data_rdy seen at cycle N is decoded in N. All outputs are registered and change at N+1.
- ld_* is high for exactly one cycle (N+1). ld_num and ld_alarm are valid in that same cycle and hold until the next strobe.
- Back-to-back bytes need at least one low cycle of rx_data_rdy between them; this holds for the UART rate.
- rst asserted mid-entry returns to IDLE at the next edge with reset values. No strobe is issued in the reset cycle.
- An 'L' or 'A' byte received in an entry state is ignored. Entry cannot be re-entered while busy.

## Structure
- Package clk_cmd_pkg holds:
  - ASCII constants: 'R', 'P', 'L', 'A', 'D', 'E', ESC, '0'.
  - Digit limits (5, 9).
  - State typedef/encoding.
- One sub-module, rdy_edge_det: registers rx_data_rdy and outputs a one-cycle rising-edge pulse; resets to 0.
- The top holds the FSM, the saved-run register, the target flag and the output registers.

## Test plan
- Reset, then 'R' → run=1 one cycle after the byte edge. Then 'P' → run=0. rx_data_rdy held high 5 cycles → only one command acts.
- After 'R', send 'L','1','2','3','4':
  - During entry, run=0.
  - Strobes occur in order ld_mtens/1, ld_mones/2, ld_stens/3, ld_sones/4, each exactly one cycle, all with ld_alarm=0.
  - run=1 after the last digit.
- 'L','7' → no strobe and state stays E_MT. Then '5','x','9' → ld_mtens/5 then ld_mones/9; 'x' is ignored.
- 'A','0','1','3','0' with run=1 → four strobes with ld_alarm=1, dsp_* constant 1, run stays 1.
- 'L','4' then ESC → IDLE with busy=0, run restored, dsp_mones blinking stops. During E_MO, dsp_mones follows blink.
- rst pulsed during E_ST → all outputs at reset values next cycle. 'D','E' → sel_led_disp=1, alarm_en=1.

Source files
------------

// File: rtl/clk_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_cmd_pkg
// Description : Shared constants, state encoding and helpers for the mm:ss
//               clock UART command decoder.
// Revision    : 1.0  initial release
// ============================================================================
package clk_cmd_pkg;

  localparam logic [7:0] C_ASCII_R   = 8'h52;
  localparam logic [7:0] C_ASCII_P   = 8'h50;
  localparam logic [7:0] C_ASCII_L   = 8'h4C;
  localparam logic [7:0] C_ASCII_A   = 8'h41;
  localparam logic [7:0] C_ASCII_D   = 8'h44;
  localparam logic [7:0] C_ASCII_E   = 8'h45;
  localparam logic [7:0] C_ASCII_ESC = 8'h1B;
  localparam logic [7:0] C_ASCII_0   = 8'h30;

  localparam logic [3:0] C_LIM_TENS  = 4'd5;
  localparam logic [3:0] C_LIM_ONES  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_E_MT = 3'd1,
    ST_E_MO = 3'd2,
    ST_E_ST = 3'd3,
    ST_E_SO = 3'd4
  } state_t;

  // Commands are case-insensitive; fold a-z onto A-Z.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b >= 8'h61 && b <= 8'h7A) begin
      r = b - 8'h20;
    end
    return r;
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= C_ASCII_0) && (b <= (C_ASCII_0 + 8'd9));
  endfunction

  function automatic logic [3:0] digit_limit(input state_t s);
    logic [3:0] lim;
    lim = C_LIM_ONES;
    if (s == ST_E_MT || s == ST_E_ST) begin
      lim = C_LIM_TENS;
    end
    return lim;
  endfunction

  // Display enables ordered {mtens, mones, stens, sones}.
  function automatic logic [3:0] dsp_mask(input state_t s, input logic alarm,
                                          input logic blink);
    logic [3:0] m;
    m = 4'hF;
    if (!alarm) begin
      case (s)
        ST_E_MT: m[3] = blink;
        ST_E_MO: m[2] = blink;
        ST_E_ST: m[1] = blink;
        ST_E_SO: m[0] = blink;
        default: m = 4'hF;
      endcase
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rdy_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : rdy_edge_det
// Description : Registers the UART byte-valid level and emits a one-cycle
//               pulse on its rising edge.
// Revision    : 1.0  initial release
// ============================================================================
module rdy_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_rdy,
  output logic o_rise
);

  logic r_rdy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdy_q <= 1'b0;
    end else begin
      r_rdy_q <= i_rdy;
    end
  end

  assign o_rise = i_rdy & ~r_rdy_q;

endmodule
`default_nettype wire

// File: rtl/clk_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : clk_cmd_decoder
// Description : Decodes UART ASCII commands into run/freeze, digit load
//               strobes, display enables and display/alarm control.
// Revision    : 1.0  initial release
// ============================================================================
module clk_cmd_decoder
  import clk_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_data_rdy,
  input  logic [7:0] i_rx_data,
  input  logic       i_blink,
  output logic       o_run,
  output logic       o_ld_mtens,
  output logic       o_ld_mones,
  output logic       o_ld_stens,
  output logic       o_ld_sones,
  output logic       o_ld_alarm,
  output logic [3:0] o_ld_num,
  output logic       o_dsp_mtens,
  output logic       o_dsp_mones,
  output logic       o_dsp_stens,
  output logic       o_dsp_sones,
  output logic       o_sel_led_disp,
  output logic       o_alarm_en,
  output logic       o_busy
);

  logic       w_rise;
  logic [7:0] w_byte_up;
  logic       w_is_esc;
  logic       w_digit_ok;
  logic [3:0] w_ld_onehot;
  logic       w_leave_clk;
  state_t     w_nxt_state;
  logic       w_nxt_tgt;

  state_t     r_state;
  logic       r_tgt;
  logic       r_run;
  logic       r_run_saved;
  logic [3:0] r_ld;
  logic       r_ld_alarm;
  logic [3:0] r_ld_num;
  logic [3:0] r_dsp;
  logic       r_sel;
  logic       r_alarm_en;
  logic       r_busy;

  rdy_edge_det u_rdy_edge_det (
    .clk    (clk),
    .rst    (rst),
    .i_rdy  (i_rx_data_rdy),
    .o_rise (w_rise)
  );

  always_comb begin
    w_byte_up   = to_upper(i_rx_data);
    w_is_esc    = (i_rx_data == C_ASCII_ESC);
    w_digit_ok  = is_digit(i_rx_data) && (i_rx_data[3:0] <= digit_limit(r_state));
    w_nxt_state = r_state;
    w_nxt_tgt   = r_tgt;
    w_ld_onehot = 4'b0000;
    case (r_state)
      ST_E_MT: w_ld_onehot = 4'b1000;
      ST_E_MO: w_ld_onehot = 4'b0100;
      ST_E_ST: w_ld_onehot = 4'b0010;
      ST_E_SO: w_ld_onehot = 4'b0001;
      default: w_ld_onehot = 4'b0000;
    endcase
    if (w_rise) begin
      case (r_state)
        ST_IDLE: begin
          if (w_byte_up == C_ASCII_L) begin
            w_nxt_state = ST_E_MT;
            w_nxt_tgt   = 1'b0;
          end else if (w_byte_up == C_ASCII_A) begin
            w_nxt_state = ST_E_MT;
            w_nxt_tgt   = 1'b1;
          end
        end
        ST_E_MT: begin
          if (w_is_esc)        w_nxt_state = ST_IDLE;
          else if (w_digit_ok) w_nxt_state = ST_E_MO;
        end
        ST_E_MO: begin
          if (w_is_esc)        w_nxt_state = ST_IDLE;
          else if (w_digit_ok) w_nxt_state = ST_E_ST;
        end
        ST_E_ST: begin
          if (w_is_esc)        w_nxt_state = ST_IDLE;
          else if (w_digit_ok) w_nxt_state = ST_E_SO;
        end
        ST_E_SO: begin
          if (w_is_esc || w_digit_ok) w_nxt_state = ST_IDLE;
        end
        default: w_nxt_state = ST_IDLE;
      endcase
    end
    // Run is only restored when a clock (not alarm) entry is left.
    w_leave_clk = w_rise && (r_state != ST_IDLE) && !r_tgt &&
                  (w_is_esc || (r_state == ST_E_SO && w_digit_ok));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tgt       <= 1'b0;
      r_run       <= 1'b0;
      r_run_saved <= 1'b0;
      r_ld        <= 4'b0000;
      r_ld_alarm  <= 1'b0;
      r_ld_num    <= 4'd0;
      r_dsp       <= 4'hF;
      r_sel       <= 1'b0;
      r_alarm_en  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_tgt   <= w_nxt_tgt;
      r_busy  <= (w_nxt_state != ST_IDLE);
      r_dsp   <= dsp_mask(w_nxt_state, w_nxt_tgt, i_blink);
      r_ld    <= 4'b0000;
      if (w_rise) begin
        if (r_state == ST_IDLE) begin
          case (w_byte_up)
            C_ASCII_R: r_run <= 1'b1;
            C_ASCII_P: r_run <= 1'b0;
            C_ASCII_L: begin
              r_run_saved <= r_run;
              r_run       <= 1'b0;
            end
            C_ASCII_D: r_sel      <= ~r_sel;
            C_ASCII_E: r_alarm_en <= ~r_alarm_en;
            default: ;
          endcase
        end else if (w_digit_ok) begin
          r_ld       <= w_ld_onehot;
          r_ld_num   <= i_rx_data[3:0];
          r_ld_alarm <= r_tgt;
        end
        if (w_leave_clk) begin
          r_run <= r_run_saved;
        end
      end
    end
  end

  assign o_run          = r_run;
  assign o_ld_mtens     = r_ld[3];
  assign o_ld_mones     = r_ld[2];
  assign o_ld_stens     = r_ld[1];
  assign o_ld_sones     = r_ld[0];
  assign o_ld_alarm     = r_ld_alarm;
  assign o_ld_num       = r_ld_num;
  assign o_dsp_mtens    = r_dsp[3];
  assign o_dsp_mones    = r_dsp[2];
  assign o_dsp_stens    = r_dsp[1];
  assign o_dsp_sones    = r_dsp[0];
  assign o_sel_led_disp = r_sel;
  assign o_alarm_en     = r_alarm_en;
  assign o_busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_clk_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_cmd_decoder
// Description : Scoreboard bench for the UART clock command decoder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_clk_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_rx_data_rdy = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_blink = 1'b0;
  logic       o_run, o_ld_mtens, o_ld_mones, o_ld_stens, o_ld_sones, o_ld_alarm;
  logic [3:0] o_ld_num;
  logic       o_dsp_mtens, o_dsp_mones, o_dsp_stens, o_dsp_sones;
  logic       o_sel_led_disp, o_alarm_en, o_busy;

  always #5 clk = ~clk;

  clk_cmd_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .i_rx_data_rdy  (i_rx_data_rdy),
    .i_rx_data      (i_rx_data),
    .i_blink        (i_blink),
    .o_run          (o_run),
    .o_ld_mtens     (o_ld_mtens),
    .o_ld_mones     (o_ld_mones),
    .o_ld_stens     (o_ld_stens),
    .o_ld_sones     (o_ld_sones),
    .o_ld_alarm     (o_ld_alarm),
    .o_ld_num       (o_ld_num),
    .o_dsp_mtens    (o_dsp_mtens),
    .o_dsp_mones    (o_dsp_mones),
    .o_dsp_stens    (o_dsp_stens),
    .o_dsp_sones    (o_dsp_sones),
    .o_sel_led_disp (o_sel_led_disp),
    .o_alarm_en     (o_alarm_en),
    .o_busy         (o_busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 idle, 1 clock entry, 2 alarm entry; pos = digit awaited.
  int m_mode, m_pos, m_num;
  bit m_run, m_saved, m_sel, m_aen, m_alarm;
  int exp_q[$];   // pos*32 + num*2 + alarm

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_num = 0;
    m_run = 0; m_saved = 0; m_sel = 0; m_aen = 0; m_alarm = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] up;
    int v, lim;
    up = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    if (m_mode == 0) begin
      if (up == "R") m_run = 1;
      else if (up == "P") m_run = 0;
      else if (up == "L") begin m_saved = m_run; m_run = 0; m_mode = 1; m_pos = 0; end
      else if (up == "A") begin m_mode = 2; m_pos = 0; end
      else if (up == "D") m_sel = ~m_sel;
      else if (up == "E") m_aen = ~m_aen;
    end else if (b == 8'h1B) begin
      if (m_mode == 1) m_run = m_saved;
      m_mode = 0;
    end else if (b >= 8'h30 && b <= 8'h39) begin
      v   = int'(b) - 48;
      lim = (m_pos == 0 || m_pos == 2) ? 5 : 9;
      if (v <= lim) begin
        m_num   = v;
        m_alarm = (m_mode == 2);
        exp_q.push_back(m_pos * 32 + v * 2 + (m_alarm ? 1 : 0));
        m_pos++;
        if (m_pos == 4) begin
          if (m_mode == 1) m_run = m_saved;
          m_mode = 0;
        end
      end
    end
  endfunction

  function automatic int exp_dsp(input int blink);
    int m;
    m = 15;
    if (m_mode == 1 && blink == 0) m = m & ~(8 >> m_pos);
    return m;
  endfunction

  function automatic int ld_vec();
    return {28'd0, o_ld_mtens, o_ld_mones, o_ld_stens, o_ld_sones};
  endfunction

  function automatic int dsp_vec();
    return {28'd0, o_dsp_mtens, o_dsp_mones, o_dsp_stens, o_dsp_sones};
  endfunction

  // Monitor: pops an expected strobe whenever the DUT issues one.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (ld_vec() != 0) begin
        if (exp_q.size() == 0) begin
          chk("strobe_unexpected", ld_vec(), 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_sel", ld_vec(), 8 >> (e / 32));
          chk("strobe_num", o_ld_num, (e / 2) % 16);
          chk("strobe_alarm", o_ld_alarm, e % 2);
        end
      end
    end
  end

  task automatic check_state();
    chk("run", o_run, m_run);
    chk("busy", o_busy, (m_mode != 0) ? 1 : 0);
    chk("sel_led_disp", o_sel_led_disp, m_sel);
    chk("alarm_en", o_alarm_en, m_aen);
    chk("ld_num_hold", o_ld_num, m_num);
    chk("ld_alarm_hold", o_ld_alarm, m_alarm);
  endtask

  task automatic check_dsp();
    for (int b = 1; b >= 0; b--) begin
      @(negedge clk);
      i_blink = b[0];
      @(negedge clk);
      chk("dsp", dsp_vec(), exp_dsp(b));
    end
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    @(negedge clk);
    i_rx_data     = b;
    i_rx_data_rdy = 1'b1;
    model_byte(b);
    @(negedge clk);
    chk("run_latency", o_run, m_run);
    chk("busy_latency", o_busy, (m_mode != 0) ? 1 : 0);
    repeat (hold - 1) @(negedge clk);
    i_rx_data_rdy = 1'b0;
    @(negedge clk);
    check_state();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pool [0:23];
    string s;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_state();
    chk("dsp_reset", dsp_vec(), 15);
    chk("ld_reset", ld_vec(), 0);

    send("R", 1);
    send("P", 5);
    send("R", 1);
    send("L", 1);
    check_dsp();
    send("1", 1); send("2", 2);
    check_dsp();
    send("3", 1); send("4", 1);
    send("L", 1); send("7", 1);
    check_dsp();
    send("5", 1); send("x", 1); send("9", 1);
    send(8'h1B, 1);
    send("A", 1); send("0", 1); send("1", 1);
    check_dsp();
    send("3", 1); send("0", 1);
    send("l", 2); send("4", 1);
    check_dsp();
    send(8'h1B, 1);
    check_dsp();

    send("L", 1); send("1", 1); send("2", 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    chk("ld_after_rst", ld_vec(), 0);
    chk("dsp_after_rst", dsp_vec(), 15);
    check_state();
    send("D", 1); send("E", 3);

    s = "RrPpLlAaDdEe0123456789xQ";
    for (int i = 0; i < 24; i++) pool[i] = s[i];
    pool[22] = 8'h1B;
    for (int i = 0; i < 250; i++) begin
      send(pool[$urandom_range(0, 23)], int'($urandom_range(1, 3)));
      if (i % 5 == 0) check_dsp();
    end

    repeat (4) @(negedge clk);
    chk("strobe_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
